// File: rtl/mvau_weight_streamer.sv
// rtl/mvau_weight_streamer.sv - cyclic weight-memory reader presenting weights as a valid/ready stream
//
// Ports:
//   aclk, areset     clock (rising edge), asynchronous active-high reset
//   en               permits issuing new weight-memory reads
//   wmem_addr        registered read address to the weight memory
//   wmem_in          memory read data, valid the cycle after its address
//   out_v/out_rdy    output handshake, a word moves when both are high
//   out_wgt/out_last weight word and end-of-pass flag (address WMEM_DEPTH-1)
//   stall_cnt        cycles with out_v & !out_rdy, saturating
//                    (present only with MVAU_WSTRM_STALL_CNT_EN defined)
module mvau_weight_streamer #(
  parameter int SIMD         = 2,
  parameter int TW           = 1,
  parameter int WMEM_DEPTH   = 4,
  parameter int WMEM_ADDR_BW = 4
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    en,
  output logic [WMEM_ADDR_BW-1:0] wmem_addr,
  input  logic [SIMD*TW-1:0]      wmem_in,
  output logic                    out_v,
  input  logic                    out_rdy,
  output logic [SIMD*TW-1:0]      out_wgt,
  output logic                    out_last
`ifdef MVAU_WSTRM_STALL_CNT_EN
  ,
  output logic [31:0]             stall_cnt
`endif
);

  localparam int WW = SIMD * TW;
  localparam logic [WMEM_ADDR_BW-1:0] LAST_ADDR = WMEM_ADDR_BW'(WMEM_DEPTH - 1);

  // Two-entry buffer: the head entry is the output register itself, so the
  // outputs never see wmem_in combinationally. tail holds the second word.
  logic [1:0]    occ;
  logic [WW-1:0] tail_wgt;
  logic          tail_last;

  logic          inflight;
  logic          inflight_last;

  logic          pop;
  logic          push;
  logic          issue;
  logic [1:0]    credit_use;

  assign out_v = (occ != 2'd0);
  assign pop   = out_v & out_rdy;
  assign push  = inflight;

  // A word leaving this cycle already frees its slot for the read issued now;
  // without counting it the 2-cycle read round trip would cap throughput
  // below one word per cycle. occ >= pop, so the subtraction cannot wrap.
  assign credit_use = occ + {1'b0, inflight} - {1'b0, pop};
  assign issue      = en & (credit_use < 2'd2);

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wmem_addr     <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_last <= (wmem_addr == LAST_ADDR);
        wmem_addr     <= (wmem_addr == LAST_ADDR) ? '0 : wmem_addr + 1'b1;
      end
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      occ       <= 2'd0;
      out_wgt   <= '0;
      out_last  <= 1'b0;
      tail_wgt  <= '0;
      tail_last <= 1'b0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ == 2'd0) begin
            out_wgt  <= wmem_in;
            out_last <= inflight_last;
          end else begin
            tail_wgt  <= wmem_in;
            tail_last <= inflight_last;
          end
          occ <= occ + 2'd1;
        end
        2'b01: begin
          if (occ == 2'd2) begin
            out_wgt  <= tail_wgt;
            out_last <= tail_last;
          end
          occ <= occ - 2'd1;
        end
        2'b11: begin
          // occ is unchanged; the newest word goes behind whatever remains.
          if (occ == 2'd1) begin
            out_wgt  <= wmem_in;
            out_last <= inflight_last;
          end else begin
            out_wgt   <= tail_wgt;
            out_last  <= tail_last;
            tail_wgt  <= wmem_in;
            tail_last <= inflight_last;
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef MVAU_WSTRM_STALL_CNT_EN
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      stall_cnt <= 32'd0;
    end else if (out_v && !out_rdy && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mvau_weight_streamer.sv
// tb/tb_mvau_weight_streamer.sv - self-checking bench for mvau_weight_streamer
module tb_mvau_weight_streamer;

  localparam int SIMD  = 2;
  localparam int TW    = 4;
  localparam int W     = SIMD * TW;
  localparam int DEPTH = 4;
  localparam int ABW   = 4;

  logic           aclk    = 1'b0;
  logic           areset  = 1'b0;
  logic           en      = 1'b0;
  logic           out_rdy = 1'b0;
  logic [ABW-1:0] wmem_addr;
  logic [W-1:0]   wmem_in = '0;
  logic           out_v;
  logic [W-1:0]   out_wgt;
  logic           out_last;
`ifdef MVAU_WSTRM_STALL_CNT_EN
  logic [31:0]    stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state: k = words accepted in the current pass sequence,
  // issued = reads observed via address advances since reset.
  int             k;
  int             issued;
  int             stall_model;
  logic [ABW-1:0] prev_addr;
  logic           prev_stall;
  logic [W-1:0]   prev_wgt;
  logic           prev_last;

  int             k0;
  int             n;
  logic [ABW-1:0] a0;

  mvau_weight_streamer #(
    .SIMD(SIMD), .TW(TW), .WMEM_DEPTH(DEPTH), .WMEM_ADDR_BW(ABW)
  ) dut (
    .aclk(aclk), .areset(areset), .en(en),
    .wmem_addr(wmem_addr), .wmem_in(wmem_in),
    .out_v(out_v), .out_rdy(out_rdy),
    .out_wgt(out_wgt), .out_last(out_last)
`ifdef MVAU_WSTRM_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 aclk = ~aclk;

  // Weight memory with registered read: mem[i] = i + 1.
  always @(posedge aclk) wmem_in <= {4'd0, wmem_addr} + 8'd1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Asynchronous pulse in the middle of a cycle; caller is at a falling edge.
  task automatic do_reset();
    #2 areset = 1'b1;
    #1;
    chk("rst_addr", 32'(wmem_addr), 32'd0);
    chk("rst_v", 32'(out_v), 32'd0);
    chk("rst_wgt", 32'(out_wgt), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
`ifdef MVAU_WSTRM_STALL_CNT_EN
    chk("rst_stall_cnt", stall_cnt, 32'd0);
`endif
    @(negedge aclk);
    areset      = 1'b0;
    k           = 0;
    issued      = 0;
    stall_model = 0;
    prev_addr   = '0;
    prev_stall  = 1'b0;
  endtask

  // One clock: drive inputs at the falling edge, score any handshake, then
  // advance to the next falling edge and check hold and credit rules.
  task automatic cycle(input logic e, input logic r);
    en      = e;
    out_rdy = r;
    if (out_v && out_rdy) begin
      chk("beat_wgt", 32'(out_wgt), 32'((k % DEPTH) + 1));
      chk("beat_last", 32'(out_last), 32'((k % DEPTH) == DEPTH - 1));
      k++;
    end
    if (out_v && !out_rdy) stall_model++;
    prev_stall = out_v && !out_rdy;
    prev_wgt   = out_wgt;
    prev_last  = out_last;
    @(posedge aclk);
    @(negedge aclk);
    if (prev_stall) begin
      chk("hold_v", 32'(out_v), 32'd1);
      chk("hold_wgt", 32'(out_wgt), 32'(prev_wgt));
      chk("hold_last", 32'(out_last), 32'(prev_last));
    end
    if (wmem_addr !== prev_addr) issued++;
    prev_addr = wmem_addr;
    chk("credit", 32'((issued - k) <= 2), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge aclk);
    en      = 1'b1;
    out_rdy = 1'b1;
    do_reset();

    // Latency: addr 0 issued in the first cycle, word visible two edges later.
    cycle(1'b1, 1'b1);
    chk("lat_addr1", 32'(wmem_addr), 32'd1);
    chk("lat_v_c1", 32'(out_v), 32'd0);
    cycle(1'b1, 1'b1);
    chk("lat_v_c2", 32'(out_v), 32'd1);
    chk("lat_wgt_first", 32'(out_wgt), 32'd1);

    // Full throughput.
    k0 = k;
    repeat (12) cycle(1'b1, 1'b1);
    chk("throughput", 32'(k - k0), 32'd12);

    // Backpressure for 10 cycles.
    repeat (3) cycle(1'b1, 1'b0);
    a0 = wmem_addr;
    repeat (7) cycle(1'b1, 1'b0);
    chk("stall_addr_frozen", 32'(wmem_addr), 32'(a0));
    chk("stall_buffered", 32'(issued - k), 32'd2);

    // Random backpressure until three more passes are delivered.
    k0 = k;
    n  = 0;
    while ((k - k0) < 12 && n < 300) begin
      cycle(1'b1, 1'($urandom_range(0, 1)));
      n++;
    end
    chk("rand_done", 32'((k - k0) >= 12), 32'd1);

    // en dropped after addresses 0 and 1 are issued.
    do_reset();
    cycle(1'b1, 1'b1);
    cycle(1'b1, 1'b1);
    chk("en_addr2", 32'(wmem_addr), 32'd2);
    repeat (6) cycle(1'b0, 1'b1);
    chk("en_off_words", 32'(k), 32'd2);
    chk("en_off_v", 32'(out_v), 32'd0);
    chk("en_off_addr", 32'(wmem_addr), 32'd2);
    n = 0;
    while (k < 4 && n < 20) begin
      cycle(1'b1, 1'b1);
      n++;
    end
    chk("en_resume_words", 32'(k), 32'd4);

    // Reset while words 3 and 4 are buffered.
    do_reset();
    n = 0;
    while (k < 2 && n < 20) begin
      cycle(1'b1, 1'b1);
      n++;
    end
    repeat (4) cycle(1'b1, 1'b0);
    chk("hold34_v", 32'(out_v), 32'd1);
    chk("hold34_wgt", 32'(out_wgt), 32'd3);
    chk("hold34_buffered", 32'(issued - k), 32'd2);
    do_reset();
    n = 0;
    while (k < 4 && n < 20) begin
      cycle(1'b1, 1'b1);
      n++;
    end
    chk("restart_words", 32'(k), 32'd4);

`ifdef MVAU_WSTRM_STALL_CNT_EN
    do_reset();
    repeat (3) cycle(1'b0, 1'b0);
    chk("stall_cnt_idle", stall_cnt, 32'd0);
    n = 0;
    while (stall_model < 5 && n < 20) begin
      cycle(1'b1, 1'b0);
      n++;
    end
    chk("stall_cnt_5", stall_cnt, 32'd5);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
